clk_enable_gen: RTL
===================

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent clock-enable channels, 1..16.
REQ-002 Parameter DIV_W, default 8: integer bits of a divisor.
REQ-003 Parameter FRAC_W, default 3: fractional bits of a divisor; the default gives 0.125 steps.
REQ-004 Parameter RESET_DIV, default 2^FRAC_W (1.0): raw fixed-point divisor loaded into every channel at reset.
REQ-005 Let W = DIV_W+FRAC_W and ONE = 2^FRAC_W.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ch_en, in, NUM_CH: per-channel run enable.
- cfg_valid, in, 1: a divisor update is offered.
- cfg_ready, out, 1: the update is accepted when cfg_valid and cfg_ready are both high.
- cfg_ch, in, clog2(NUM_CH) (min 1): target channel.
- cfg_div, in, W: unsigned fixed-point divisor.
- ce_o, out, NUM_CH: one-cycle clock-enable pulses.
- pending_o, out, NUM_CH: an accepted update is waiting to apply.

Function
REQ-007 Each channel holds a divisor register div (W bits), an accumulator acc (W+1 bits), a pending flag and a pending divisor.
REQ-008 Enabled channel, every edge:
- sum = acc + ONE.
- If sum >= div: acc <= sum - div and ce_o bit <= 1.
- Otherwise: acc <= sum and ce_o bit <= 0.
REQ-009 ce_o is registered; no combinational path exists from any input to ce_o.
REQ-010 Resulting average period is div/ONE clk cycles, with a maximum-to-minimum spacing jitter of 1 cycle. Example: 2.5 gives spacings 3,2,3,2...
REQ-011 For an integer divisor D, the first pulse is registered on the D-th consecutive edge with ch_en high, counted from acc = 0.
REQ-012 Disabled channel (ch_en bit low): acc <= 0 and ce_o bit <= 0 on every edge.
REQ-013 cfg_ready = !pending[cfg_ch]. cfg_ready is combinational from cfg_ch and the pending flags only.
REQ-014 On acceptance:
- pending[cfg_ch] <= 1.
- Pending divisor <= max(cfg_div, ONE); a divisor below 1.0, including 0, is clamped to 1.0.
REQ-015 A pending update applies on the first subsequent edge where that channel registers a pulse, or where its ch_en is low. On that edge: div <= pending divisor, acc <= 0, pending <= 0.
REQ-016 An update therefore never shortens or stretches the period in progress. The pulse on the switch edge still belongs to the old divisor.
REQ-017 An update to one channel never alters the acc, div or ce_o of any other channel.
REQ-018 A second offer to a channel whose pending flag is set is stalled (cfg_ready low) until that flag clears. Offers to other channels proceed.
REQ-019 An out-of-range cfg_ch (>= NUM_CH) drives cfg_ready high and the accepted transfer is discarded.
REQ-020 No overflow is possible: acc < div <= 2^W - 1 always holds, and sum fits in W+1 bits.
REQ-021 pending_o mirrors the pending flags.

Reset
REQ-022 While rst_n is low, asynchronously:
- acc <= 0, div <= RESET_DIV, pending <= 0.
- ce_o <= 0 and pending_o <= 0.
REQ-023 Reset asserted mid-period or with an update pending discards both. The first post-reset pulse follows REQ-011 using RESET_DIV.

Configuration
REQ-024 When CLK_ENABLE_TOGGLE_EN is defined, an added output port toggle_o [NUM_CH] flips its bit on every edge where the matching ce_o bit is registered high.
- This yields a square wave at half the pulse rate.
- toggle_o resets to 0 and holds while the channel is disabled.
REQ-025 When CLK_ENABLE_TOGGLE_EN is undefined, toggle_o and its flops do not exist; all other behaviour is identical.

Verification
REQ-026 Reset check: FRAC_W=3, RESET_DIV=8, ch_en=all-1 after reset -> ce_o = 1 on every cycle from the first edge.
REQ-027 Fractional divisor: update ch0 to 20 (2.5) -> after the switch, pulse spacing is 3,2,3,2; 40 pulses span exactly 100 cycles.
REQ-028 Boundary switch: ch0 at div 80 (10.0), offer 16 (2.0) mid-period -> pending_o[0]=1 and the current 10-cycle period completes. Afterwards the spacing is 2, and a second offer to ch0 sees cfg_ready=0 until the switch.
REQ-029 Clamp and disable: offer cfg_div=0 to ch1 while ch_en[1]=0 -> applied on the next edge with div=8 and pending_o[1]=0; enabling ch1 then pulses every cycle.
REQ-030 Reset mid-operation: ch0 at 2.5 with an update pending, pulse rst_n low for 1 cycle -> ce_o=0 and pending_o=0 immediately, and div returns to RESET_DIV.
REQ-031 Macro build: with CLK_ENABLE_TOGGLE_EN and div 16 -> toggle_o[0] has period 4 cycles and 50% duty.

Source files
------------

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_enable_gen
// Description : Multi-channel fractional clock-enable generator. Each channel
//               adds 1.0 to a phase accumulator on every enabled edge and
//               emits a registered one-cycle pulse whenever the accumulator
//               reaches its fixed-point divisor, giving an average period of
//               div/2^FRAC_W cycles with at most one cycle of spacing jitter.
//               Divisor updates arrive over a valid/ready port and are held
//               pending until the channel's next pulse (or until the channel
//               is disabled), so a period in progress is never disturbed.
// Options     : CLK_ENABLE_TOGGLE_EN - adds toggle_o, a per-channel square
//               wave that flips on every pulse (half the pulse rate).
// Revision    : 1.0 - initial release
// ============================================================================

module clk_enable_gen #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int FRAC_W    = 3,
    parameter int RESET_DIV = 2 ** FRAC_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_CH-1:0]                         ch_en,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W+FRAC_W-1:0]                   cfg_div,
    output logic [NUM_CH-1:0]                         ce_o,
    output logic [NUM_CH-1:0]                         pending_o
`ifdef CLK_ENABLE_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0]                         toggle_o
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_w    = DIV_W + FRAC_W;
    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // 1.0 in divisor width and in accumulator (one bit wider) width
    localparam logic [c_w-1:0] c_one       = c_w'(1) << FRAC_W;
    localparam logic [c_w:0]   c_one_acc   = (c_w + 1)'(1) << FRAC_W;
    localparam logic [c_w-1:0] c_reset_div = c_w'(RESET_DIV);

    // ------------------------------------------------------------------------
    // Shared configuration-port logic
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] w_pend_vec;     // pending flags gathered from channels
    logic              w_sel_pend;     // pending flag of the addressed channel
    logic              w_accept;       // an update transfer happens this edge
    logic [c_w-1:0]    w_cfg_div_clamp;

    // Select the addressed channel's pending flag; an out-of-range channel
    // matches nothing, reads as not pending and therefore always accepts.
    always_comb begin
        w_sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == c_ch_w'(i)) begin
                w_sel_pend = w_pend_vec[i];
            end
        end
    end

    assign cfg_ready = !w_sel_pend;
    assign w_accept  = cfg_valid && cfg_ready;

    // Divisors below 1.0 (including 0) would fire more than once per edge,
    // which one pulse bit cannot express, so they are raised to 1.0.
    assign w_cfg_div_clamp = (cfg_div < c_one) ? c_one : cfg_div;

    assign pending_o = w_pend_vec;

    // ------------------------------------------------------------------------
    // Per-channel accumulator, divisor and pending-update machinery
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [c_w-1:0] r_div;     // active divisor
            logic [c_w-1:0] r_pdiv;    // divisor waiting to be applied
            logic [c_w:0]   r_acc;     // phase accumulator, always < r_div
            logic           r_pend;    // an accepted update is waiting
            logic           r_ce;      // registered pulse

            logic [c_w:0]   w_sum;     // accumulator after adding 1.0
            logic [c_w:0]   w_wrap;    // accumulator after wrapping
            logic           w_fire;    // this edge registers a pulse
            logic           w_apply;   // this edge switches to r_pdiv
            logic           w_hit;     // this edge accepts an update for us

            // acc < div <= 2^W-1 and 1.0 <= div, so the sum fits in W+1 bits
            // and at most one wrap is ever needed.
            assign w_sum  = r_acc + c_one_acc;
            assign w_wrap = w_sum - {1'b0, r_div};
            assign w_fire = ch_en[gi] && (w_sum >= {1'b0, r_div});

            // A waiting divisor is only swapped in at a period boundary or
            // while idle, so the pulse on the switch edge uses the old one.
            assign w_apply = r_pend && (!ch_en[gi] || w_fire);

            assign w_hit = w_accept && (cfg_ch == c_ch_w'(gi));

            // Accumulator and active divisor: restart from zero on a switch
            // or while disabled, otherwise advance by 1.0 with wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                    r_div <= c_reset_div;
                end else if (w_apply) begin
                    r_acc <= '0;
                    r_div <= r_pdiv;
                end else if (!ch_en[gi]) begin
                    r_acc <= '0;
                end else if (w_fire) begin
                    r_acc <= w_wrap;
                end else begin
                    r_acc <= w_sum;
                end
            end

            // Pending flag and held divisor. Acceptance needs the flag clear
            // and a switch needs it set, so the two never meet on one edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pend <= 1'b0;
                    r_pdiv <= c_reset_div;
                end else if (w_hit) begin
                    r_pend <= 1'b1;
                    r_pdiv <= w_cfg_div_clamp;
                end else if (w_apply) begin
                    r_pend <= 1'b0;
                end
            end

            // Pulse output register; keeps ce_o free of input-to-output paths.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ce <= 1'b0;
                end else begin
                    r_ce <= w_fire;
                end
            end

            assign ce_o[gi]       = r_ce;
            assign w_pend_vec[gi] = r_pend;

`ifdef CLK_ENABLE_TOGGLE_EN
            logic r_tog;               // square wave at half the pulse rate

            // Flip on every registered pulse; a disabled channel never fires
            // so its toggle simply holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tog <= 1'b0;
                end else if (w_fire) begin
                    r_tog <= ~r_tog;
                end
            end

            assign toggle_o[gi] = r_tog;
`endif
        end
    endgenerate

endmodule

`default_nettype wire
